// File: rtl/uart_stream_rx.sv
// 8N1 UART receiver feeding a small FIFO that is drained through a valid/ready byte stream.
// o_tlast flags LAST_CHAR bytes, and line errors or dropped bytes are reported as one-cycle pulses.
module uart_stream_rx #(
    parameter int         CLKS_PER_BIT = 278,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] LAST_CHAR    = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic             rx_meta;
    logic             rx_s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       idx;
    logic [2:0]       idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             push;
    logic             frame_err_next;

    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shift       <= shift_next;
            o_frame_err <= frame_err_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        idx_next       = idx;
        shift_next     = shift;
        push           = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (rx_s) begin
                    state_next = IDLE;
                end else begin
                    state_next = DATA;
                    cnt_next   = BIT_LOAD;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    shift_next = {rx_s, shift[7:1]};
                    cnt_next   = BIT_LOAD;
                    // The 3-bit index wraps to 0 after bit 7.
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (rx_s) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else begin
                    frame_err_next = 1'b1;
                    state_next     = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic [8:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           empty;
    logic           full;
    logic           pop;
    logic           write;

    // The extra pointer MSB separates full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop   = !empty && i_tready;
    assign write = push && (!full || pop);

    // NOTE: the storage array is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (write) begin
            mem[wr_ptr[PTR_W-1:0]] <= {shift == LAST_CHAR, shift};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_overflow <= push && full && !pop;
        end
    end

    // Outputs are forced to zero when the FIFO is empty, so stale storage never reaches the stream.
    assign o_tvalid           = !empty;
    assign {o_tlast, o_tdata} = empty ? 9'd0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_uart_stream_rx.sv
// Scoreboard bench for uart_stream_rx: serial stimulus pushes expected beats, and a negedge monitor pops and compares them.
// The reference rules are byte order, LAST_CHAR marking, drop-when-stalled-full, and one error per bad stop bit.
`timescale 1ns/1ps
module tb_uart_stream_rx;

    localparam int         CPB   = 16;
    localparam int         DEPTH = 4;
    localparam logic [7:0] LAST  = 8'h0A;
    // Cycles from the line falling to o_tvalid: 2 sync flops, half a bit, 9 bit periods, then 1 push cycle.
    localparam int         LATENCY = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       uart_rx = 1'b1;
    logic       tready  = 1'b0;
    logic [7:0] tdata;
    logic       tlast;
    logic       tvalid;
    logic       frame_err;
    logic       overflow;

    uart_stream_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .LAST_CHAR   (LAST)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_uart_rx  (uart_rx),
        .o_tdata    (tdata),
        .o_tlast    (tlast),
        .o_tvalid   (tvalid),
        .i_tready   (tready),
        .o_frame_err(frame_err),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int beats    = 0;
    int exp_ferr = 0;
    int obs_ferr = 0;
    int exp_ovf  = 0;
    int obs_ovf  = 0;
    int ready_mode = 0;  // 0 stalled, 1 always ready, 2 random
    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst   = 1'b0;
    logic [8:0] prev_beat  = '0;

    always @(negedge clk) begin
        if (rst_n && prev_rst && prev_valid && !prev_ready) begin
            check("stall_valid_held", tvalid, 1);
            check("stall_beat_held", {tlast, tdata}, prev_beat);
        end
        if (rst_n) begin
            if (tvalid && !prev_valid) rise_cyc = cyc;
            if (frame_err) obs_ferr++;
            if (overflow) obs_ovf++;
            if (tvalid && tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat (t=%0t)", {tlast, tdata}, $time);
                end else begin
                    check("beat", {tlast, tdata}, exp_q.pop_front());
                end
            end
        end
        prev_valid = tvalid;
        prev_ready = tready;
        prev_beat  = {tlast, tdata};
        prev_rst   = rst_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (!stop) exp_ferr++;
        else if (ready_mode == 0 && exp_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back({b == LAST, b});
        fall_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        logic [7:0] partial;

        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(5);
        check("post_reset_tvalid", tvalid, 0);

        ready_mode = 1;
        tick(2);
        send_byte(8'h55, 1'b1);
        tick(20);
        check("tvalid_latency", rise_cyc - fall_cyc, LATENCY);
        check("drained_55", exp_q.size(), 0);

        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h0A, 1'b1);
        tick(20);
        check("drained_AB_nl", exp_q.size(), 0);

        send_byte(8'h3C, 1'b0);
        tick(CPB);
        send_byte(8'h7E, 1'b1);
        tick(20);
        check("frame_err_count", obs_ferr, exp_ferr);
        check("drained_7E", exp_q.size(), 0);

        uart_rx = 1'b0;
        exp_ferr++;
        tick(12 * CPB);
        uart_rx = 1'b1;
        tick(2 * CPB);
        check("break_err_count", obs_ferr, exp_ferr);

        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(2 * CPB);
        check("glitch_no_err", obs_ferr, exp_ferr);
        check("glitch_no_beat", tvalid, 0);
        send_byte(8'hA5, 1'b1);
        tick(20);
        check("drained_A5", exp_q.size(), 0);

        ready_mode = 0;
        tick(4);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
        tick(20);
        check("overflow_count", obs_ovf, exp_ovf);
        check("stalled_tvalid", tvalid, 1);
        b0 = beats;
        ready_mode = 1;
        tick(4);
        check("back_to_back_beats", beats - b0, DEPTH);
        check("drained_tvalid", tvalid, 0);
        check("drained_overflow", exp_q.size(), 0);

        ready_mode = 0;
        tick(2);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(20);
        partial = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(partial[i]);
        uart_rx = partial[3];
        tick(CPB / 2);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        exp_q.delete();
        tick(3);
        check_idle_outputs("mid_reset");
        rst_n = 1'b1;
        tick(1);
        check("after_reset_tvalid", tvalid, 0);
        ready_mode = 1;
        tick(4 * CPB);
        check("reset_no_err", obs_ferr, exp_ferr);
        send_byte(8'h99, 1'b1);
        tick(20);
        check("drained_99", exp_q.size(), 0);

        ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? LAST : 8'($urandom);
            send_byte(b, 1'b1);
            tick($urandom_range(0, 20));
        end
        tick(40);
        check("drained_random", exp_q.size(), 0);
        check("final_frame_err", obs_ferr, exp_ferr);
        check("final_overflow", obs_ovf, exp_ovf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_stream_rx.md
UART_STREAM_RX -- requirements
Module: uart_stream_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 278: i_clk cycles per UART bit (16 MHz / 57600 baud); SHALL be >= 8.
REQ-002 Parameter FIFO_DEPTH, default 16: receive FIFO entries; SHALL be a power of 2, >= 2.
REQ-003 Parameter LAST_CHAR, default 8'h0A: byte value that marks end of packet.
REQ-004 i_clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_uart_rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 o_tdata  output  8  stream byte.
REQ-008 o_tlast  output  1  high with the byte equal to LAST_CHAR.
REQ-009 o_tvalid  output  1  stream valid.
REQ-010 i_tready  input  1  stream ready from consumer.
REQ-011 o_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-012 o_overflow  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-013 i_uart_rx SHALL pass through a 2-flop synchronizer; both flops reset to 1. All following rules use the synchronized value rx_s.
REQ-014 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A single bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) SHALL drive the sampling.
REQ-015 IDLE: when rx_s is 0, go to START and load the counter so the next sample falls CLKS_PER_BIT/2 (integer division) cycles later.
REQ-016 START: at the sample point, go to DATA if rx_s is 0; if rx_s is 1 (glitch), return to IDLE with no output and no error.
REQ-017 DATA: sample every CLKS_PER_BIT cycles after the start sample. Shift each bit in LSB first. After bit 7, go to STOP.
REQ-018 STOP: at the sample point, if rx_s is 1, push {byte, byte==LAST_CHAR} into the FIFO and go to IDLE. If rx_s is 0, pulse o_frame_err for exactly one cycle, discard the byte and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until rx_s is 1, then go to IDLE. A break (line held low) SHALL produce exactly one o_frame_err.
REQ-020 Push latency: o_tvalid SHALL rise on the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-021 o_tvalid = FIFO not empty. o_tdata/o_tlast = head entry. A pop occurs when o_tvalid && i_tready.
REQ-022 While o_tvalid && !i_tready, o_tdata and o_tlast SHALL hold stable. o_tvalid SHALL not drop without a pop.
REQ-023 Back-to-back pops SHALL sustain one byte per cycle.
REQ-024 Push when full and no pop in the same cycle: byte dropped, o_overflow pulses one cycle, FIFO contents unchanged.
REQ-025 Push when full with a pop in the same cycle: push accepted, no overflow.
REQ-026 Simultaneous push and pop on an empty FIFO SHALL be impossible; a push into an empty FIFO appears next cycle.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL use a log2(FIFO_DEPTH)+1-bit count or an extra pointer bit, so full and empty are distinct.
REQ-028 Receiver timing SHALL be independent of i_tready; reception continues while the consumer stalls.

Reset
REQ-029 While i_rst_n is 0 at a clock edge, the following SHALL hold on the next cycle:
- FSM = IDLE; counters = 0; synchronizer = 1;
- FIFO empty;
- o_tvalid = 0, o_tlast = 0, o_tdata = 0, o_frame_err = 0, o_overflow = 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no push and no error pulse. After reset release, a line still low SHALL be treated as a start edge only once it is observed 0 in IDLE.
REQ-031 Reset SHALL discard all FIFO contents, including any entry pending on the stream.

Verification
REQ-032 CLKS_PER_BIT=16. Send 0x55 with i_tready=1 -> one beat o_tdata=0x55, o_tlast=0. o_tvalid rises one cycle after the stop sample.
REQ-033 Send "AB\n" (0x41, 0x42, 0x0A) with i_tready=1 -> three beats; o_tlast=1 only on 0x0A.
REQ-034 i_tready=0 with FIFO_DEPTH=4; send 6 bytes 0x01..0x06. Then raise i_tready.
- Expect two o_overflow pulses (bytes 5 and 6).
- Output is 0x01..0x04, in order, with tdata stable while stalled.
REQ-035 Send 0x3C with stop bit forced 0, then line high, then 0x7E -> one o_frame_err pulse, no beat for 0x3C, one beat 0x7E.
REQ-036 Start-bit glitch of 4 cycles low (< CLKS_PER_BIT/2) -> no output and no error. A following valid 0xA5 is received correctly.
REQ-037 Assert i_rst_n=0 during bit 3 of a frame with 2 bytes queued; release and send 0x99 -> o_tvalid=0 right after reset, then a single beat 0x99.
